// File: rtl/dcache_data_array.sv
// N-way set-associative data store with byte-strobed stores and 1-cycle load latency,
// plus an eviction sequencer that streams a dirty victim out and absorbs the refill line.
module dcache_data_array #(
  parameter  int WAYS       = 2,
  parameter  int SETS       = 64,
  parameter  int LINE_BYTES = 32,
  localparam int BEATS      = LINE_BYTES / 8,
  localparam int IW         = $clog2(SETS),
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WW         = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [7:0]      req_wstrb,
  input  logic [WAYS-1:0] req_way,
  input  logic [IW-1:0]   req_index,
  input  logic [BW-1:0]   req_beat,
  input  logic [63:0]     req_wdata,
  output logic            rsp_valid,
  output logic [63:0]     rsp_rdata,
  input  logic            evict_start,
  input  logic [WW-1:0]   evict_way,
  input  logic [IW-1:0]   evict_index,
  input  logic            evict_dirty,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [63:0]     wb_data,
  output logic            wb_last,
  input  logic            refill_valid,
  output logic            refill_ready,
  input  logic [63:0]     refill_data,
  output logic            line_done
);

  localparam int AW = WW + IW + BW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

  state_t          state_q;
  logic [BW-1:0]   cnt_q;
  logic [WW-1:0]   vway_q;
  logic [IW-1:0]   vidx_q;
  logic            wb_valid_q;
  logic            wb_last_q;
  logic [63:0]     wb_data_q;
  logic            rsp_valid_q;
  logic [63:0]     rsp_rdata_q;
  logic            line_done_q;

  // Flat storage addressed as {way, index, beat}; contents are never reset.
  logic [63:0]     mem_q [0:(1<<AW)-1];

  logic [WW-1:0]   hit_way;
  logic            req_hit;
  logic            accept;
  logic [BW-1:0]   cnt_d;
  logic [AW-1:0]   req_addr;
  logic [AW-1:0]   fill_addr;

  // Lowest-numbered set bit of the hit vector wins.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (req_way[w]) hit_way = WW'(w);
    end
  end

  assign req_hit   = |req_way;
  assign req_ready = (state_q == S_IDLE) && !evict_start;
  assign accept    = req_valid && req_ready;
  assign cnt_d     = cnt_q + 1'b1;
  assign req_addr  = {hit_way, req_index, req_beat};
  assign fill_addr = {vway_q, vidx_q, cnt_q};

  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && req_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wstrb[b]) mem_q[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end else if (!rst && state_q == S_REFILL && refill_valid) begin
      mem_q[fill_addr] <= refill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vway_q      <= '0;
      vidx_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_last_q   <= 1'b0;
      wb_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      line_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept && !req_we;
      if (accept && !req_we) rsp_rdata_q <= req_hit ? mem_q[req_addr] : '0;
      line_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (evict_start) begin
            vway_q <= evict_way;
            vidx_q <= evict_index;
            cnt_q  <= '0;
            if (evict_dirty) begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              wb_data_q  <= mem_q[{evict_way, evict_index, BW'(0)}];
              wb_last_q  <= (LAST_BEAT == '0);
            end else begin
              state_q <= S_REFILL;
            end
          end
        end
        S_WB: begin
          // Beat data and last flag only move on a completed handshake.
          if (wb_ready) begin
            if (wb_last_q) begin
              state_q    <= S_REFILL;
              wb_valid_q <= 1'b0;
              wb_last_q  <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q     <= cnt_d;
              wb_data_q <= mem_q[{vway_q, vidx_q, cnt_d}];
              wb_last_q <= (cnt_d == LAST_BEAT);
            end
          end
        end
        S_REFILL: begin
          if (refill_valid) begin
            cnt_q <= cnt_d;
            if (cnt_q == LAST_BEAT) begin
              state_q     <= S_IDLE;
              line_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_last      = wb_last_q;
  assign refill_ready = (state_q == S_REFILL);
  assign line_done    = line_done_q;

endmodule

// File: tb/tb_dcache_data_array.sv
// Directed bench for dcache_data_array: a line-level model (arrays + write-back queue)
// is compared against the DUT every cycle, alongside hand-computed literal checks.
module tb_dcache_data_array;
  localparam int WAYS = 2, SETS = 64, BEATS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_way;
  logic [5:0]  req_index;
  logic [1:0]  req_beat;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        evict_start, evict_way, evict_dirty;
  logic [5:0]  evict_index;
  logic        wb_valid, wb_ready, wb_last;
  logic [63:0] wb_data;
  logic        refill_valid, refill_ready;
  logic [63:0] refill_data;
  logic        line_done;

  dcache_data_array dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wstrb(req_wstrb),
    .req_way(req_way), .req_index(req_index), .req_beat(req_beat), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .evict_start(evict_start), .evict_way(evict_way), .evict_index(evict_index),
    .evict_dirty(evict_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_data(refill_data),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit cmp_en = 0;
  int ld_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Line-level model: contents per way/set/beat, pending write-back beats, refill beats left.
  typedef enum {M_IDLE, M_WB, M_REF} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [63:0] mm [WAYS][SETS][BEATS];
  bit          kn [WAYS][SETS][BEATS];
  logic [63:0] wbq[$];
  int          m_way, m_idx, m_left;
  bit          e_rsp_v, e_rsp_kn, e_ld;
  logic [63:0] e_rsp_d;

  always @(posedge clk) begin
    bit rdy;
    int w;
    if (rst) begin
      m_mode = M_IDLE;
      wbq.delete();
      e_rsp_v = 0;
      e_ld = 0;
    end else begin
      rdy = (m_mode == M_IDLE) && !evict_start;
      e_rsp_v = 0;
      e_ld = 0;
      if (req_valid && rdy) begin
        w = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (req_way[i]) w = i;
        if (req_we) begin
          if (w >= 0) begin
            for (int b = 0; b < 8; b++)
              if (req_wstrb[b]) mm[w][req_index][req_beat][b*8 +: 8] = req_wdata[b*8 +: 8];
            if (req_wstrb == 8'hFF) kn[w][req_index][req_beat] = 1;
          end
        end else begin
          e_rsp_v = 1;
          if (w < 0) begin
            e_rsp_d = 0;
            e_rsp_kn = 1;
          end else begin
            e_rsp_d = mm[w][req_index][req_beat];
            e_rsp_kn = kn[w][req_index][req_beat];
          end
        end
      end
      case (m_mode)
        M_IDLE: if (evict_start) begin
          m_way = int'(evict_way);
          m_idx = int'(evict_index);
          if (evict_dirty) begin
            for (int b = 0; b < BEATS; b++) wbq.push_back(mm[m_way][m_idx][b]);
            m_mode = M_WB;
          end else begin
            m_mode = M_REF;
            m_left = BEATS;
          end
        end
        M_WB: if (wb_ready) begin
          void'(wbq.pop_front());
          if (wbq.size() == 0) begin
            m_mode = M_REF;
            m_left = BEATS;
          end
        end
        M_REF: if (refill_valid) begin
          mm[m_way][m_idx][BEATS-m_left] = refill_data;
          kn[m_way][m_idx][BEATS-m_left] = 1;
          m_left--;
          if (m_left == 0) begin
            e_ld = 1;
            m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chkb("req_ready", req_ready, (m_mode == M_IDLE) && !evict_start);
      chkb("rsp_valid", rsp_valid, e_rsp_v);
      if (e_rsp_v && e_rsp_kn) chk("rsp_rdata", rsp_rdata, e_rsp_d);
      chkb("wb_valid", wb_valid, m_mode == M_WB);
      if (m_mode == M_WB && wbq.size() > 0) begin
        chk("wb_data", wb_data, wbq[0]);
        chkb("wb_last", wb_last, wbq.size() == 1);
      end
      chkb("refill_ready", refill_ready, m_mode == M_REF);
      chkb("line_done", line_done, e_ld);
      if (line_done) ld_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [7:0] strb, input logic [1:0] way,
                        input int idx, input int beat, input logic [63:0] d);
    req_valid = 1; req_we = we; req_wstrb = strb; req_way = way;
    req_index = idx[5:0]; req_beat = beat[1:0]; req_wdata = d;
    tick();
    req_valid = 0; req_we = 0;
  endtask

  task automatic load_chk(input string nm, input logic [1:0] way, input int idx,
                          input int beat, input logic [63:0] exp);
    do_req(0, 8'h00, way, idx, beat, 64'h0);
    chkb({nm, "_valid"}, rsp_valid, 1'b1);
    chk(nm, rsp_rdata, exp);
  endtask

  task automatic evict(input logic way, input int idx, input logic dirty);
    evict_start = 1; evict_way = way; evict_index = idx[5:0]; evict_dirty = dirty;
    tick();
    evict_start = 0;
  endtask

  logic [63:0] got[$];
  logic        gotl[$];

  task automatic run_wb(input logic [15:0] pat, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      wb_ready = pat[c];
      @(negedge clk);
      if (wb_valid && wb_ready) begin
        got.push_back(wb_data);
        gotl.push_back(wb_last);
      end
      tick();
    end
    wb_ready = 0;
  endtask

  task automatic run_refill(input logic [63:0] base, input logic [15:0] vpat,
                            input int ncyc, output int acc);
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      refill_valid = (acc < BEATS) && vpat[c];
      refill_data = base + 64'(acc);
      @(negedge clk);
      if (refill_valid && refill_ready) acc++;
      tick();
    end
    refill_valid = 0;
  endtask

  task automatic check_wb(input string nm, input logic [63:0] base);
    chk({nm, "_count"}, 64'(got.size()), 64'(BEATS));
    if (got.size() == BEATS) begin
      for (int k = 0; k < BEATS; k++) begin
        chk($sformatf("%s_beat%0d", nm, k), got[k], base + 64'(k));
        chkb($sformatf("%s_last%0d", nm, k), gotl[k], k == BEATS - 1);
      end
    end
  endtask

  initial begin
    int acc;
    bit accepted;
    rst = 1; req_valid = 0; req_we = 0; req_wstrb = 0; req_way = 0; req_index = 0;
    req_beat = 0; req_wdata = 0; evict_start = 0; evict_way = 0; evict_index = 0;
    evict_dirty = 0; wb_ready = 0; refill_valid = 0; refill_data = 0;
    repeat (3) tick();
    rst = 0;
    cmp_en = 1;
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_wb_valid", wb_valid, 1'b0);
    chkb("rst_refill_ready", refill_ready, 1'b0);
    chkb("rst_line_done", line_done, 1'b0);
    chkb("rst_req_ready", req_ready, 1'b1);

    // Full-word store, read-back, other way untouched, multi-hot picks way0.
    do_req(1, 8'hFF, 2'b10, 5, 2, 64'hDEADBEEF00000001);
    do_req(1, 8'hFF, 2'b01, 5, 2, 64'h1122334455667788);
    load_chk("ld_way0", 2'b01, 5, 2, 64'h1122334455667788);
    load_chk("ld_way1", 2'b10, 5, 2, 64'hDEADBEEF00000001);
    load_chk("ld_multihot", 2'b11, 5, 2, 64'h1122334455667788);

    // Byte-strobe merge and miss behaviour.
    do_req(1, 8'hFF, 2'b01, 7, 1, 64'hFFFFFFFFFFFFFFFF);
    do_req(1, 8'h01, 2'b01, 7, 1, 64'h00000000000000AB);
    load_chk("strb_merge", 2'b01, 7, 1, 64'hFFFFFFFFFFFFFFAB);
    do_req(1, 8'hFF, 2'b00, 7, 1, 64'h0);
    load_chk("miss_store_nochg", 2'b01, 7, 1, 64'hFFFFFFFFFFFFFFAB);
    load_chk("miss_load_zero", 2'b00, 7, 1, 64'h0);

    // Dirty eviction with a stalling write channel, then refill.
    for (int b = 0; b < BEATS; b++) do_req(1, 8'hFF, 2'b10, 63, b, 64'hA0 + 64'(b));
    ld_count = 0;
    got.delete(); gotl.delete();
    evict(1'b1, 63, 1'b1);
    run_wb(16'h03ED, 10);
    check_wb("dirty_wb", 64'hA0);
    run_refill(64'hB0, 16'hFFFF, 8, acc);
    chk("dirty_refill_acc", 64'(acc), 64'(BEATS));
    repeat (2) tick();
    chk("dirty_line_done_cnt", 64'(ld_count), 64'd1);
    for (int b = 0; b < BEATS; b++)
      load_chk($sformatf("refill_ld%0d", b), 2'b10, 63, b, 64'hB0 + 64'(b));

    // Clean eviction colliding with a held load; second evict during refill ignored.
    ld_count = 0;
    req_valid = 1; req_we = 0; req_way = 2'b01; req_index = 6'd5; req_beat = 2'd2;
    evict_start = 1; evict_way = 1'b0; evict_index = 6'd7; evict_dirty = 1'b0;
    @(negedge clk);
    chkb("evict_prio_ready", req_ready, 1'b0);
    tick();
    evict_start = 0;
    chkb("clean_refill_ready", refill_ready, 1'b1);
    chkb("clean_no_wb", wb_valid, 1'b0);
    evict(1'b1, 63, 1'b1);
    chkb("evict_ignored_refill", refill_ready, 1'b1);
    run_refill(64'hC0, 16'h001D, 6, acc);
    chk("clean_refill_acc", 64'(acc), 64'(BEATS));
    accepted = 0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready) accepted = 1;
      tick();
    end
    req_valid = 0;
    chkb("held_req_accepted", accepted, 1'b1);
    chkb("held_rsp_valid", rsp_valid, 1'b1);
    chk("held_rsp_data", rsp_rdata, 64'h1122334455667788);
    chk("clean_line_done_cnt", 64'(ld_count), 64'd1);
    refill_valid = 1; refill_data = 64'h5555;
    tick();
    refill_valid = 0;
    load_chk("idle_refill_ignored", 2'b01, 7, 0, 64'hC0);
    load_chk("clean_refill_ld3", 2'b01, 7, 3, 64'hC3);

    // Reset in the middle of a write-back, then a full eviction from beat 0.
    for (int b = 0; b < BEATS; b++) do_req(1, 8'hFF, 2'b10, 3, b, 64'hD0 + 64'(b));
    ld_count = 0;
    got.delete(); gotl.delete();
    evict(1'b1, 3, 1'b1);
    run_wb(16'h0003, 2);
    rst = 1;
    tick();
    chkb("midwb_rst_wb_valid", wb_valid, 1'b0);
    chkb("midwb_rst_refill_ready", refill_ready, 1'b0);
    chkb("midwb_rst_line_done", line_done, 1'b0);
    rst = 0;
    tick();
    chk("midwb_no_line_done", 64'(ld_count), 64'd0);
    got.delete(); gotl.delete();
    evict(1'b1, 3, 1'b1);
    run_wb(16'h00FF, 6);
    check_wb("post_rst_wb", 64'hD0);
    run_refill(64'hE0, 16'hFFFF, 6, acc);
    repeat (2) tick();
    chk("post_rst_line_done_cnt", 64'(ld_count), 64'd1);
    load_chk("post_rst_ld2", 2'b10, 3, 2, 64'hE2);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_data_array.md
Name: dcache_data_array

Overview:
Parametrised N-way set-associative data store for the NPC data cache. It supports multi-beat cache lines, byte-strobed stores and a 1-cycle read latency. It also contains a built-in eviction/refill sequencer: it streams a dirty victim line out to the AXI bridge, then absorbs the refill line. It sits between the LSU-side cache controller (which supplies the hit way from the tag array) and the AXI read/write channels.

Parameters:
WAYS, 2, number of ways (power of two, ≥2)
SETS, 64, number of sets (power of two)
LINE_BYTES, 32, bytes per line (multiple of 8); BEATS = LINE_BYTES/8 64-bit beats per line
IW = clog2(SETS), BW = clog2(BEATS) (max 1), WW = clog2(WAYS): derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU access request
req_ready  out  1  request accepted this cycle when high with req_valid
req_we  in  1  1 = store, 0 = load
req_wstrb  in  8  byte write enables for store
req_way  in  WAYS  one-hot hit vector from tag array (all-zero = miss)
req_index  in  IW  set index
req_beat  in  BW  beat within line
req_wdata  in  64  store data
rsp_valid  out  1  load data valid
rsp_rdata  out  64  load data
evict_start  in  1  begin line replacement (1-cycle pulse)
evict_way  in  WW  victim way
evict_index  in  IW  victim set
evict_dirty  in  1  victim must be written back first
wb_valid  out  1  write-back beat valid
wb_ready  in  1  AXI write channel ready
wb_data  out  64  write-back beat
wb_last  out  1  final write-back beat
refill_valid  in  1  refill beat valid
refill_ready  out  1  block accepts refill beat
refill_data  in  64  refill beat
line_done  out  1  1-cycle pulse: refill complete

Behaviour:
- Reset (sync, active-high): state=IDLE, beat counter=0, and all outputs 0 (req_ready is combinational and is 1 once in IDLE with evict_start low). Array contents are not reset; line validity is owned by the tag array. Reset mid-write-back/refill aborts the operation with no line_done.
- FSM states: IDLE, WB, REFILL.
  - IDLE→WB on evict_start & evict_dirty.
  - IDLE→REFILL on evict_start & ~evict_dirty.
  - WB→REFILL on handshake of the last beat.
  - REFILL→IDLE on acceptance of beat BEATS-1; line_done pulses in the cycle after that beat is accepted.
- Victim way and index are latched on evict_start.
- req_ready = (state==IDLE) & ~evict_start. evict_start has priority over a same-cycle request.
- Load accepted in cycle T: rsp_valid=1 and rsp_rdata=array[way][index][beat] in cycle T+1. rsp_rdata is 0 if req_way is all-zero. Multi-hot req_way: the lowest-numbered set bit wins. rsp_valid is otherwise 0.
- Store accepted in cycle T: bytes with req_wstrb[i]=1 are updated at the clock edge ending T; other bytes are unchanged. No response is generated. A miss (req_way=0) leaves the array unchanged. A load of the same location in T+1 returns the new data.
- WB:
  - wb_valid rises the cycle after evict_start, carrying beat 0.
  - The beat counter advances only on wb_valid & wb_ready.
  - wb_data and wb_last are held stable while wb_valid & ~wb_ready.
  - wb_last=1 only with beat BEATS-1.
  - There are no bubbles between beats when wb_ready stays high.
- REFILL:
  - refill_ready=1 throughout REFILL.
  - Each refill_valid beat writes a full 64 bits to the latched way/index at beat=counter, then the counter increments.
  - The counter wraps to 0 after beat BEATS-1.
  - refill_valid outside REFILL is ignored.
- evict_start outside IDLE is ignored.
- Width rules: beat and index are used unsigned; the counter is BW bits wide and wraps naturally.

Test Plan:
- Store 0x1122334455667788, wstrb=0xFF, way0, index 5, beat 2, then load the same location in the next cycle → rsp_valid=1 and rsp_rdata=0x1122334455667788 one cycle after acceptance. Then load way1 at the same location → the way1 value is returned, unaffected.
- Byte-strobe merge: line holds 0xFFFFFFFFFFFFFFFF; store 0x00000000000000AB with wstrb=0x01, then load → 0xFFFFFFFFFFFFFFAB. Store and load with req_way=0 → array unchanged and rsp_rdata=0.
- Dirty eviction of way1, index 63, line beats 0xA0..0xA3 (BEATS=4), with wb_ready toggling 1,0,1,1,0,1 → beats A0,A1,A2,A3 are emitted in order, held stable during stalls, and wb_last=1 only on A3. Then 4 refill beats 0xB0..0xB3 → line_done pulses once, and loads return B0..B3.
- Clean eviction with evict_dirty=0 → wb_valid is never asserted and refill_ready=1 from the next cycle. req_ready=0 for the whole replacement; req_valid held high is accepted only after returning to IDLE.
- evict_start and req_valid in the same IDLE cycle → req_ready=0 and the eviction proceeds. A second evict_start during REFILL is ignored.
- Assert rst in the middle of the WB phase → next cycle state=IDLE, wb_valid=0, refill_ready=0, no line_done. A new eviction afterwards runs correctly from beat 0.
